// File: rtl/dsp_mul_checker.sv
// Self-checking stimulus source for an 18x18 DSP multiplier: issues LFSR operand
// pairs, predicts each product and compares it against p after LATENCY cycles.
module dsp_mul_checker #(
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [17:0] SEED_A      = 18'h1ACE5,
  parameter logic [17:0] SEED_B      = 18'h0B00B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [17:0] a,
  output logic [17:0] b,
  input  logic [35:0] p,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx
);

  localparam int unsigned OP_W   = 18;
  localparam int unsigned PROD_W = 36;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [OP_W-1:0]  SEED_A_EFF = (SEED_A == '0) ? 18'h00001 : SEED_A;
  localparam logic [OP_W-1:0]  SEED_B_EFF = (SEED_B == '0) ? 18'h00001 : SEED_B;
  localparam logic [IDX_W-1:0] NO_ERR     = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [OP_W-1:0]      r_a;
  logic [OP_W-1:0]      r_b;
  logic [OP_W-1:0]      r_lfsr_a;
  logic [OP_W-1:0]      r_lfsr_b;
  logic [IDX_W-1:0]     r_vec_idx;
  logic [IDX_W-1:0]     r_cmp_idx;
  logic [CNT_W-1:0]     r_drain_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [IDX_W-1:0]     r_err_count;
  logic [IDX_W-1:0]     r_first_err;
  logic [LATENCY-1:0]   r_pipe_vld;
  logic [PROD_W-1:0]    r_pipe_exp [LATENCY];

  logic                 w_start_acc;
  logic                 w_issue;
  logic [PROD_W-1:0]    w_exp;
  logic                 w_tail_vld;
  logic                 w_mismatch;
  logic [IDX_W-1:0]     w_err_next;

  // x^18 + x^11 + 1, shifting toward the MSB
  function automatic logic [OP_W-1:0] lfsr_step(input logic [OP_W-1:0] s);
    return {s[OP_W-2:0], s[17] ^ s[10]};
  endfunction

  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue     = (r_state == S_RUN);
  // Unsigned a times signed b, kept modulo 2^36
  assign w_exp       = PROD_W'({{(PROD_W-OP_W){1'b0}}, r_a}) *
                       PROD_W'({{(PROD_W-OP_W){r_b[OP_W-1]}}, r_b});
  assign w_tail_vld  = r_pipe_vld[LATENCY-1];
  assign w_mismatch  = w_tail_vld && (p != r_pipe_exp[LATENCY-1]);
  assign w_err_next  = (w_mismatch && (r_err_count != 16'hFFFF)) ?
                       r_err_count + 16'd1 : r_err_count;

  // Expectation pipe: the tail lines up with p LATENCY cycles after issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_pipe_exp[i] <= '0;
    end else begin
      if (w_start_acc) begin
        r_pipe_vld <= '0;
      end else begin
        r_pipe_vld[0] <= w_issue;
        for (int unsigned i = 1; i < LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
      r_pipe_exp[0] <= w_exp;
      for (int unsigned i = 1; i < LATENCY; i++) r_pipe_exp[i] <= r_pipe_exp[i-1];
    end
  end

  // Run sequencer, operand generation and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_lfsr_a    <= SEED_A_EFF;
      r_lfsr_b    <= SEED_B_EFF;
      r_vec_idx   <= '0;
      r_cmp_idx   <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_first_err <= NO_ERR;
    end else begin
      // Comparison at the pipe tail; a start below overrides these updates
      if (w_mismatch) begin
        r_err_count <= w_err_next;
        if (r_first_err == NO_ERR) r_first_err <= r_cmp_idx;
      end
      if (w_tail_vld) r_cmp_idx <= r_cmp_idx + 16'd1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_a         <= SEED_A_EFF;
            r_b         <= SEED_B_EFF;
            r_lfsr_a    <= lfsr_step(SEED_A_EFF);
            r_lfsr_b    <= lfsr_step(SEED_B_EFF);
            r_vec_idx   <= 16'd1;
            r_cmp_idx   <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_first_err <= NO_ERR;
          end
        end
        S_RUN: begin
          if (r_vec_idx == IDX_W'(NUM_VECTORS)) begin
            r_state     <= S_DRAIN;
            r_a         <= '0;
            r_b         <= '0;
            r_drain_cnt <= '0;
          end else begin
            r_a       <= r_lfsr_a;
            r_b       <= r_lfsr_b;
            r_lfsr_a  <= lfsr_step(r_lfsr_a);
            r_lfsr_b  <= lfsr_step(r_lfsr_b);
            r_vec_idx <= r_vec_idx + 16'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == CNT_W'(LATENCY - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a             = r_a;
  assign b             = r_b;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err;

endmodule

// File: tb/tb_dsp_mul_checker.sv
// Bench for dsp_mul_checker: drives a behavioural DSP multiplier with selectable
// latency and fault injection, and scoreboards operands and run results.
module tb_dsp_mul_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [17:0] a, b;
  logic [35:0] p;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;

  logic        start_op;
  logic [17:0] a_op, b_op;
  logic [35:0] p_op;
  logic        busy_op, done_op, pass_op;
  logic [15:0] err_op, first_op;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        pass;
    logic        any_err;
    logic [15:0] err;
    logic [15:0] first;
  } res_t;

  res_t        q_res [$];
  logic [35:0] q_ops [$];

  always #5 clk = ~clk;

  dsp_mul_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .p(p),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  dsp_mul_checker #(.LATENCY(3), .NUM_VECTORS(1), .SEED_A(18'h3FFFF), .SEED_B(18'h20000)) u_op (
    .clk(clk), .rst_n(rst_n), .start(start_op), .a(a_op), .b(b_op), .p(p_op),
    .busy(busy_op), .done(done_op), .pass(pass_op),
    .err_count(err_op), .first_err_idx(first_op)
  );

  function automatic logic [35:0] ref_mul(input logic [17:0] x, input logic [17:0] y);
    logic signed [36:0] xs, ys, prod;
    xs   = $signed(37'(x));
    ys   = 37'($signed(y));
    prod = xs * ys;
    return prod[35:0];
  endfunction

  function automatic logic [17:0] lfsr_next(input logic [17:0] s);
    return {s[16:0], s[17] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural DSP model: 3 registers, optional early tap, optional bit-0 fault
  int          m_lat     = 3;
  int          m_corrupt = -1;
  int          m_idx     = 0;
  logic [35:0] m1 = '0, m2 = '0, m3 = '0;
  always @(posedge clk) begin
    if (start && !busy) m_idx <= 0;
    else if (a != '0)   m_idx <= m_idx + 1;
    m1 <= ref_mul(a, b) ^ 36'((a != '0 && m_idx == m_corrupt) ? 1 : 0);
    m2 <= m1;
    m3 <= m2;
  end
  assign p = (m_lat == 2) ? m2 : m3;

  logic [35:0] o1 = '0, o2 = '0, o3 = '0;
  always @(posedge clk) begin
    o1 <= ref_mul(a_op, b_op);
    o2 <= o1;
    o3 <= o2;
  end
  assign p_op = o3;

  // Operand scoreboard: every issued pair must match the reference LFSR stream
  always @(negedge clk) begin
    if (rst_n && busy && a != '0) begin
      if (q_ops.size() == 0) begin
        chk("op_unexpected", 36'({a, b}), 36'd0);
      end else begin
        logic [35:0] e;
        e = q_ops.pop_front();
        chk("vec_a", 36'(a), 36'(e[35:18]));
        chk("vec_b", 36'(b), 36'(e[17:0]));
      end
    end
  end

  task automatic push_ops(input int n);
    logic [17:0] sa, sb;
    sa = 18'h1ACE5;
    sb = 18'h0B00B;
    for (int i = 0; i < n; i++) begin
      q_ops.push_back({sa, sb});
      sa = lfsr_next(sa);
      sb = lfsr_next(sb);
    end
  endtask

  task automatic do_run(input int lat, input int corrupt, input bit mid_start, input res_t exp_r);
    int   cyc;
    int   busy_cyc;
    res_t e;
    m_lat     = lat;
    m_corrupt = corrupt;
    push_ops(256);
    q_res.push_back(exp_r);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 0;
    busy_cyc = 0;
    while (!done && cyc < 5000) begin
      if (busy) busy_cyc++;
      start = mid_start && (cyc == 50);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 36'(done), 36'd1);
    chk("busy_cycles", 36'(busy_cyc), 36'd259);
    e = q_res.pop_front();
    chk("pass", 36'(pass), 36'(e.pass));
    if (e.any_err) chk("err_nonzero", 36'(err_count != 16'd0), 36'd1);
    else           chk("err_count", 36'(err_count), 36'(e.err));
    chk("first_err_idx", 36'(first_err_idx), 36'(e.first));
    chk("ops_consumed", 36'(q_ops.size()), 36'd0);
  endtask

  initial begin
    int cyc;
    rst_n    = 1'b0;
    start    = 1'b0;
    start_op = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a", 36'(a), 36'd0);
    chk("rst_b", 36'(b), 36'd0);
    chk("rst_busy", 36'(busy), 36'd0);
    chk("rst_done", 36'(done), 36'd0);
    chk("rst_pass", 36'(pass), 36'd0);
    chk("rst_err", 36'(err_count), 36'd0);
    chk("rst_first", 36'(first_err_idx), 36'hFFFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_wait", 36'(busy), 36'd0);

    // Ideal multiplier, with a start pulse mid-run that must be ignored
    do_run(3, -1, 1'b1, '{pass: 1'b1, any_err: 1'b0, err: 16'd0, first: 16'hFFFF});
    repeat (5) @(negedge clk);
    chk("done_hold", 36'(done), 36'd1);
    chk("pass_hold", 36'(pass), 36'd1);

    // Single-bit fault on vector 17, started from DONE
    do_run(3, 17, 1'b0, '{pass: 1'b0, any_err: 1'b0, err: 16'd1, first: 16'd17});
    // Restart from DONE clears the previous error count
    do_run(3, -1, 1'b0, '{pass: 1'b1, any_err: 1'b0, err: 16'd0, first: 16'hFFFF});
    // Multiplier one cycle too fast
    do_run(2, -1, 1'b0, '{pass: 1'b0, any_err: 1'b1, err: 16'd0, first: 16'd0});

    // Reset in the middle of a run
    m_lat     = 3;
    m_corrupt = -1;
    push_ops(256);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 36'(busy), 36'd0);
    chk("midrst_a", 36'(a), 36'd0);
    chk("midrst_done", 36'(done), 36'd0);
    chk("midrst_err", 36'(err_count), 36'd0);
    chk("midrst_first", 36'(first_err_idx), 36'hFFFF);
    q_ops.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle", 36'(busy), 36'd0);
    do_run(3, -1, 1'b0, '{pass: 1'b1, any_err: 1'b0, err: 16'd0, first: 16'hFFFF});

    // Extreme operands: unsigned 3FFFF times signed -2^17
    @(negedge clk);
    start_op = 1'b1;
    @(negedge clk);
    start_op = 1'b0;
    chk("opchk_a", 36'(a_op), 36'h3FFFF);
    chk("opchk_b", 36'(b_op), 36'h20000);
    repeat (3) @(negedge clk);
    chk("opchk_p", p_op, 36'h800020000);
    cyc = 0;
    while (!done_op && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("opchk_done", 36'(done_op), 36'd1);
    chk("opchk_pass", 36'(pass_op), 36'd1);
    chk("opchk_err", 36'(err_op), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
